// File: rtl/shift_lr_pkg.sv
// Shared definitions for the shift_lr rotator: direction codes, bit reversal and a
// behavioural rotate reference (used when SHIFT_LR_REF_CHECK_EN is defined).
package shift_lr_pkg;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   // Helpers work on a wide container; callers pass their real width in w.
   localparam int unsigned MAX_W     = 64;
   localparam int unsigned MAX_IDX_W = $clog2(MAX_W);

   function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v,
                                                    input int unsigned      w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < w) r[MAX_IDX_W'(i)] = v[MAX_IDX_W'(w - 1 - i)];
      end
      return r;
   endfunction

   // Index-arithmetic rotate, independent of the staged network.
   function automatic logic [MAX_W-1:0] rot_ref(input logic [MAX_W-1:0] a,
                                                input int unsigned      amt,
                                                input logic             dir,
                                                input int unsigned      w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < w) begin
            case (dir)
               DIR_RIGHT: r[MAX_IDX_W'(i)] = a[MAX_IDX_W'((i + amt) % w)];
               default:   r[MAX_IDX_W'(i)] = a[MAX_IDX_W'((i + w - (amt % w)) % w)];
            endcase
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_lr_stage_core.sv
// Combinational barrel rotator: log2 cascaded right-rotate stages, with left
// rotation obtained by bit-reversing before and after the network.
module shift_lr_stage_core
   import shift_lr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   input  logic             choice,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] w_a_rev;
   logic [WIDTH-1:0] w_out_rev;
   logic [WIDTH-1:0] w_stage [AMT_W+1];

   assign w_a_rev    = WIDTH'(bit_reverse(MAX_W'(a), WIDTH));
   assign w_stage[0] = (choice == DIR_LEFT) ? w_a_rev : a;

   // Stage k rotates right by 2^k when amt[k] is set.
   for (genvar k = 0; k < AMT_W; k++) begin : g_stage
      localparam int unsigned SH = 1 << k;
      assign w_stage[k+1] = amt[k] ? {w_stage[k][SH-1:0], w_stage[k][WIDTH-1:SH]}
                                   : w_stage[k];
   end

   assign w_out_rev = WIDTH'(bit_reverse(MAX_W'(w_stage[AMT_W]), WIDTH));
   assign y         = (choice == DIR_LEFT) ? w_out_rev : w_stage[AMT_W];

endmodule

// File: rtl/shift_lr_rotator.sv
// Registered barrel rotator, one result per clock with 1-cycle latency.
// Define SHIFT_LR_REF_CHECK_EN to add a reference cross-check and the mismatch output.
module shift_lr_rotator
   import shift_lr_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   input  logic             choice,
   output logic             out_valid,
   output logic [WIDTH-1:0] y
`ifdef SHIFT_LR_REF_CHECK_EN
   ,
   output logic             mismatch
`endif
);

   logic [WIDTH-1:0] w_rot;
   logic [WIDTH-1:0] r_y;
   logic             r_valid;

   shift_lr_stage_core #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_core (
      .a      (a),
      .amt    (amt),
      .choice (choice),
      .y      (w_rot)
   );

   // y only loads on valid input so idle-cycle inputs never disturb it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_y     <= '0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) r_y <= w_rot;
      end
   end

   assign out_valid = r_valid;
   assign y         = r_y;

`ifdef SHIFT_LR_REF_CHECK_EN
   logic [WIDTH-1:0] w_ref;
   logic             r_mismatch;

   assign w_ref = WIDTH'(rot_ref(MAX_W'(a), 32'(amt), choice, WIDTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_mismatch <= 1'b0;
      else       r_mismatch <= in_valid && (w_ref != w_rot);
   end

   assign mismatch = r_mismatch;

   always @(posedge clk) begin
      if (!reset && in_valid && (w_ref != w_rot))
         $error("shift_lr_rotator: core %h != reference %h", w_rot, w_ref);
   end
`endif

endmodule

// File: tb/tb_shift_lr_rotator.sv
// Directed bench for shift_lr_rotator: literal expectations plus a per-cycle
// compare against a word-doubling rotate model.
module tb_shift_lr_rotator;

   localparam int unsigned W  = 8;
   localparam int unsigned AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [W-1:0]  a;
   logic [AW-1:0] amt;
   logic          choice;
   logic          out_valid;
   logic [W-1:0]  y;
`ifdef SHIFT_LR_REF_CHECK_EN
   logic          mismatch;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   logic m_valid = 1'b0;
   logic [W-1:0] m_y = '0;

   shift_lr_rotator #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .a         (a),
      .amt       (amt),
      .choice    (choice),
      .out_valid (out_valid),
      .y         (y)
`ifdef SHIFT_LR_REF_CHECK_EN
      ,
      .mismatch  (mismatch)
`endif
   );

   always #5 clk = ~clk;

   // Rotate by taking a window of the word written twice in a row.
   function automatic logic [W-1:0] rot_model(input logic [W-1:0] da,
                                              input logic [AW-1:0] dm,
                                              input logic dc);
      logic [2*W-1:0] d;
      d = {da, da};
      if (dc) d = d << dm;
      else    d = d >> dm;
      return dc ? d[2*W-1:W] : d[W-1:0];
   endfunction

   task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [W-1:0] da, input logic [AW-1:0] dm,
                        input logic dc);
      in_valid = v;
      a        = da;
      amt      = dm;
      choice   = dc;
      @(posedge clk);
      #1;
      if (v) m_y = rot_model(da, dm, dc);
      m_valid = v;
   endtask

   task automatic idle();
      drive(1'b0, W'($urandom), AW'($urandom), 1'($urandom));
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         check("out_valid", {7'b0, out_valid}, {7'b0, m_valid});
         check("y", y, m_y);
`ifdef SHIFT_LR_REF_CHECK_EN
         check("mismatch", {7'b0, mismatch}, 8'h00);
`endif
      end
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      amt      = '0;
      choice   = 1'b0;
      #12;
      check("reset_y", y, 8'h00);
      check("reset_valid", {7'b0, out_valid}, 8'h00);
      reset = 1'b0;
      idle();
      idle();
      check("post_reset_y", y, 8'h00);

      drive(1'b1, 8'b11010111, 3'd1, 1'b0); check("rr1", y, 8'b11101011);
      check("rr1_valid", {7'b0, out_valid}, 8'h01);
      drive(1'b1, 8'b11010111, 3'd4, 1'b0); check("rr4", y, 8'b01111101);
      drive(1'b1, 8'b11010111, 3'd7, 1'b0); check("rr7", y, 8'b10101111);

      drive(1'b1, 8'b11110011, 3'd1, 1'b1); check("rl1", y, 8'b11100111);
      drive(1'b1, 8'b11110011, 3'd3, 1'b1); check("rl3", y, 8'b10011111);
      drive(1'b1, 8'b11110011, 3'd7, 1'b1); check("rl7", y, 8'b11111001);

      drive(1'b1, 8'b00000001, 3'd3, 1'b1); check("walk_l3", y, 8'b00001000);
      drive(1'b1, 8'b00000001, 3'd4, 1'b0); check("walk_r4", y, 8'b00010000);
      drive(1'b1, 8'b00000001, 3'd5, 1'b0); check("walk_r5", y, 8'b00001000);

      drive(1'b1, 8'hA5, 3'd0, 1'b0); check("id_right", y, 8'hA5);
      drive(1'b1, 8'hA5, 3'd0, 1'b1); check("id_left", y, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         idle();
         check("hold_y", y, 8'hA5);
         check("hold_valid", {7'b0, out_valid}, 8'h00);
      end

      // Asynchronous reset between edges while a result is pending.
      drive(1'b1, 8'h3C, 3'd2, 1'b0);
      in_valid = 1'b1;
      a        = 8'hFF;
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_y", y, 8'h00);
      check("async_rst_valid", {7'b0, out_valid}, 8'h00);
      m_y     = '0;
      m_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_discard_y", y, 8'h00);
      @(negedge clk);
      #1;
      reset = 1'b0;
      idle();
      check("after_rst_y", y, 8'h00);

      for (int i = 0; i < 12; i++)
         drive(1'b1, W'($urandom), AW'($urandom), 1'($urandom));
      idle();

`ifdef SHIFT_LR_REF_CHECK_EN
      for (int d = 0; d < 2; d++)
         for (int m = 0; m < 8; m++)
            for (int v = 0; v < 256; v++)
               drive(1'b1, W'(v), AW'(m), 1'(d));
      idle();
`endif

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
